// File: rtl/sr_ff_bank.sv
// sr_ff_bank: multi-channel clocked SR flip-flop bank.
// Each channel is set or cleared on the rising clock edge. MODE selects
// what happens when both s and r are high. Per-channel conflict pulses are
// produced, together with a saturating count of cycles that had a conflict.
// Optional build macro SR_FF_BANK_SYNC_EN: when it is defined, s and r pass
// through a 2-flop synchroniser before the SR logic.
module sr_ff_bank #(
  parameter int CH    = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CH-1:0]    s,
  input  logic [CH-1:0]    r,
  input  logic             clr_cnt,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    qn,
  output logic [CH-1:0]    conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Unsupported MODE values fall back to hold.
  localparam int MODE_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CH-1:0] s_eff;
  logic [CH-1:0] r_eff;
  logic [CH-1:0] conf_vec;
  logic [CH-1:0] q_next;

  // Per-bit SR resolution; s=r=1 is resolved according to MODE_EFF.
  function automatic logic [CH-1:0] sr_next(input logic [CH-1:0] cur,
                                            input logic [CH-1:0] sv,
                                            input logic [CH-1:0] rv);
    logic [CH-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < CH; i++) begin
      case ({sv[i], rv[i]})
        2'b10: nxt[i] = 1'b1;
        2'b01: nxt[i] = 1'b0;
        2'b11: begin
          case (MODE_EFF)
            1:       nxt[i] = 1'b1;
            2:       nxt[i] = 1'b0;
            3:       nxt[i] = ~cur[i];
            default: nxt[i] = cur[i];
          endcase
        end
        default: nxt[i] = cur[i];
      endcase
    end
    return nxt;
  endfunction

  // Saturating increment: the counter sticks at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

`ifdef SR_FF_BANK_SYNC_EN
  logic [CH-1:0] s_p0, s_p1;
  logic [CH-1:0] r_p0, r_p1;

  // Two-flop synchroniser for s and r. Reset drops any requests still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p0 <= '0;
      s_p1 <= '0;
      r_p0 <= '0;
      r_p1 <= '0;
    end else begin
      // stage p0 -> p1
      s_p0 <= s;
      r_p0 <= r;
      s_p1 <= s_p0;
      r_p1 <= r_p0;
    end
  end

  assign s_eff = s_p1;
  assign r_eff = r_p1;
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  assign conf_vec = s_eff & r_eff;
  assign q_next   = sr_next(q, s_eff, r_eff);

  // SR storage; qn is registered alongside q so the two never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      qn <= '1;
    end else if (en) begin
      q  <= q_next;
      qn <= ~q_next;
    end
  end

  // Conflict pulse: high for the cycle after an enabled edge where s=r=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= '0;
    end else begin
      conflict <= en ? conf_vec : '0;
    end
  end

  // Conflict counter: one increment per conflicting cycle; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (clr_cnt) begin
      conflict_cnt <= '0;
    end else if (en && (|conf_vec)) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: directed-vector bench for sr_ff_bank.
// Four MODE variants plus a narrow-counter variant share the same stimulus.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] s = 8'h00;
  logic [7:0] r = 8'h00;
  logic       clr_cnt = 1'b0;

  logic [7:0] q0, qn0, cf0, q1, qn1, cf1, q2, qn2, cf2, q3, qn3, cf3, qc, qnc, cfc;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic [1:0] cntc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.CH(8), .MODE(0), .CNT_W(8)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
    .q(q0), .qn(qn0), .conflict(cf0), .conflict_cnt(cnt0));
  sr_ff_bank #(.CH(8), .MODE(1), .CNT_W(8)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
    .q(q1), .qn(qn1), .conflict(cf1), .conflict_cnt(cnt1));
  sr_ff_bank #(.CH(8), .MODE(2), .CNT_W(8)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
    .q(q2), .qn(qn2), .conflict(cf2), .conflict_cnt(cnt2));
  sr_ff_bank #(.CH(8), .MODE(3), .CNT_W(8)) u_m3 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
    .q(q3), .qn(qn3), .conflict(cf3), .conflict_cnt(cnt3));
  sr_ff_bank #(.CH(8), .MODE(0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
    .q(qc), .qn(qnc), .conflict(cfc), .conflict_cnt(cntc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();

`ifndef SR_FF_BANK_SYNC_EN
    // Reset state
    chk("rst_q", 32'(q0), 32'h00);
    chk("rst_qn", 32'(qn0), 32'hFF);
    chk("rst_cf", 32'(cf0), 32'h00);
    chk("rst_cnt", 32'(cnt0), 32'h00);
    rst = 1'b0;
    en  = 1'b1;

    // Set / reset / hold
    s = 8'h0F; r = 8'h00; tick();
    chk("set_q", 32'(q0), 32'h0F);
    chk("set_qn", 32'(qn0), 32'hF0);
    s = 8'h00; r = 8'h03; tick();
    chk("clr_q", 32'(q0), 32'h0C);
    s = 8'h00; r = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_q", 32'(q0), 32'h0C);
    chk("hold_qn", 32'(qn0), 32'hF3);
    chk("hold_cf", 32'(cf0), 32'h00);

    // Conflict on channel 0 in each MODE, two cycles
    s = 8'h01; r = 8'h01; tick();
    chk("c1_m0", 32'(q0), 32'h0C);
    chk("c1_m1", 32'(q1), 32'h0D);
    chk("c1_m2", 32'(q2), 32'h0C);
    chk("c1_m3", 32'(q3), 32'h0D);
    chk("c1_qn3", 32'(qn3), 32'hF2);
    chk("c1_cf0", 32'(cf0), 32'h01);
    chk("c1_cf3", 32'(cf3), 32'h01);
    tick();
    chk("c2_m0", 32'(q0), 32'h0C);
    chk("c2_m1", 32'(q1), 32'h0D);
    chk("c2_m2", 32'(q2), 32'h0C);
    chk("c2_m3", 32'(q3), 32'h0C);
    chk("c2_cf1", 32'(cf1), 32'h01);
    chk("c2_cf2", 32'(cf2), 32'h01);
    chk("c2_cnt0", 32'(cnt0), 32'd2);
    chk("c2_cnt1", 32'(cnt1), 32'd2);
    chk("c2_cnt2", 32'(cnt2), 32'd2);
    chk("c2_cnt3", 32'(cnt3), 32'd2);
    s = 8'h00; r = 8'h00; tick();
    chk("c3_cf0", 32'(cf0), 32'h00);
    chk("c3_cnt0", 32'(cnt0), 32'd2);

    // Enable gating
    en = 1'b0; s = 8'hFF; r = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("en0_q0", 32'(q0), 32'h0C);
      chk("en0_q1", 32'(q1), 32'h0D);
      chk("en0_qn1", 32'(qn1), 32'hF2);
      chk("en0_cf", 32'(cf0), 32'h00);
      chk("en0_cnt", 32'(cnt0), 32'd2);
    end

    // Asynchronous reset mid-run from q=A5
    en = 1'b1; s = 8'hA5; r = 8'h5A; tick();
    chk("pre_rst_q", 32'(q0), 32'hA5);
    #3 rst = 1'b1;
    #1;
    chk("arst_q", 32'(q0), 32'h00);
    chk("arst_qn", 32'(qn0), 32'hFF);
    chk("arst_cnt", 32'(cnt0), 32'h00);
    s = 8'h00; r = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_q", 32'(q0), 32'h00);
    chk("post_rst_qn", 32'(qn0), 32'hFF);

    // Saturating counter (CNT_W=2) against wide counter
    s = 8'h80; r = 8'h80;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_cnt2", 32'(cntc), (i < 3) ? 32'(i) : 32'd3);
      chk("sat_cnt8", 32'(cnt0), 32'(i));
      chk("sat_cf", 32'(cfc), 32'h80);
    end
    chk("tog_q3", 32'(q3), 32'h80);
    chk("tog_qn3", 32'(qn3), 32'h7F);
    clr_cnt = 1'b1; tick();
    chk("clr_cnt2", 32'(cntc), 32'd0);
    chk("clr_cnt8", 32'(cnt0), 32'd0);
    clr_cnt = 1'b0; tick();
    chk("after_clr2", 32'(cntc), 32'd1);
    chk("after_clr8", 32'(cnt0), 32'd1);

    // clr_cnt honoured with en=0
    en = 1'b0; clr_cnt = 1'b1; tick();
    chk("clr_en0", 32'(cnt0), 32'd0);
    chk("clr_en0_cf", 32'(cf0), 32'h00);
    clr_cnt = 1'b0; s = 8'h00; r = 8'h00;
`else
    // Reset state
    chk("rst_q", 32'(q0), 32'h00);
    chk("rst_qn", 32'(qn0), 32'hFF);
    rst = 1'b0;
    en  = 1'b1;

    // s[0] pulse at edge N reaches q after edge N+2
    s = 8'h01; tick();
    s = 8'h00;
    chk("sy_n0", 32'(q0), 32'h00);
    tick();
    chk("sy_n1", 32'(q0), 32'h00);
    tick();
    chk("sy_n2", 32'(q0), 32'h01);
    chk("sy_n2_qn", 32'(qn0), 32'hFE);

    // Clear again through the synchroniser
    r = 8'h01; tick();
    r = 8'h00;
    tick();
    chk("sy_r1", 32'(q0), 32'h01);
    tick();
    chk("sy_r2", 32'(q0), 32'h00);

    // Conflict through the synchroniser
    s = 8'h01; r = 8'h01; tick();
    s = 8'h00; r = 8'h00;
    tick();
    chk("sy_cf1", 32'(cf0), 32'h00);
    tick();
    chk("sy_cf2", 32'(cf0), 32'h01);
    chk("sy_cnt", 32'(cnt0), 32'd1);
    chk("sy_q1", 32'(q1), 32'h01);

    // Reset one cycle after a pulse drops it
    s = 8'h01; tick();
    s = 8'h00; tick();
    #2 rst = 1'b1;
    #1;
    chk("sy_arst", 32'(q1), 32'h00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sy_drop", 32'(q0), 32'h00);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=0", 1);
    $fatal(1);
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised, clocked multi-channel SR flip-flop bank; successor to the single-bit SR storage element.
- Each of CH channels holds one bit, set/cleared by its own S/R pair on the clock edge.
- Behaviour when S=R=1 is selectable at elaboration time.
- Reports S=R=1 conflicts per channel and keeps a saturating conflict counter for debug/status logic.

Parameters:
- CH, 8, number of independent SR channels (1..32).
- MODE, 0, resolution when S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle; any other value behaves as 0.
- CNT_W, 8, width of conflict_cnt (2..16).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  sample enable; when 0 all state holds.
- s  input  CH  per-channel set request.
- r  input  CH  per-channel reset request.
- clr_cnt  input  1  synchronous clear of conflict_cnt.
- q  output  CH  stored bits.
- qn  output  CH  complement of q, registered together with q.
- conflict  output  CH  one-cycle pulse per channel that sampled s=r=1.
- conflict_cnt  output  CNT_W  saturating count of enabled cycles with any conflict.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-operation):
  - q=0, qn=all ones, conflict=0, conflict_cnt=0.
  - Holds while rst=1; first update occurs on the first rising clk edge after rst deasserts.
- Per channel i, rising clk edge with en=1 (effective inputs shown; see Optional Feature):
  - s=0 r=0: q holds.
  - s=1 r=0: q=1.
  - s=0 r=1: q=0.
  - s=1 r=1: MODE 0 hold; MODE 1 q=1; MODE 2 q=0; MODE 3 q=~q.
- Outputs:
  - qn=~q at every edge; never equal to q, including in reset.
  - Latency: input sampled at edge N is visible on q/qn after edge N.
- Conflict flag:
  - conflict[i]=1 for exactly the cycle after an enabled edge where s[i]=r[i]=1, regardless of MODE; otherwise 0.
  - Consecutive conflicting cycles give a continuous high level.
- en=0:
  - q, qn and conflict_cnt hold; conflict=0.
  - s/r are ignored.
  - clr_cnt is still honoured.
- conflict_cnt:
  - Increments by 1 on each enabled edge where any channel conflicts (one increment per cycle, not per channel).
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 forces 0 and wins over a same-cycle increment.
- Channels are fully independent; simultaneous activity on all channels is legal.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SR_FF_BANK_SYNC_EN.
- Defined:
  - s and r pass through a 2-flop synchroniser per bit, reset to 0, before the SR logic.
  - en is not synchronised.
  - Latency from s/r to q and conflict is 3 edges.
  - On reset the synchroniser clears, so requests in flight are dropped.
- Not defined:
  - s/r are used directly.
  - Latency is 1 edge.
  - The synchroniser flops are not instantiated.

Test Plan:
- Reset: rst=1 mid-run with q=8'hA5 -> q=8'h00, qn=8'hFF, conflict_cnt=0 immediately without clock; after release with s=r=0, q stays 8'h00.
- Set/reset/hold, CH=8 MODE=0:
  - s=8'h0F r=0 -> q=8'h0F next cycle.
  - then s=0 r=8'h03 -> q=8'h0C.
  - then s=r=0 for 5 cycles -> q=8'h0C, qn=8'hF3.
- Conflict per MODE, channel 0 starting q=0, s=r=1 for 2 cycles:
  - MODE0 -> 0,0.
  - MODE1 -> 1,1.
  - MODE2 -> 0,0.
  - MODE3 -> 1,0.
  - In every MODE: conflict[0]=1 both cycles, conflict_cnt=2.
- Enable gating: en=0, s=8'hFF, r=8'hFF for 4 cycles -> q unchanged, conflict=0, conflict_cnt unchanged.
- Counter: CNT_W=2, 5 conflicting cycles -> count 1,2,3,3,3; then clr_cnt=1 concurrent with a conflict -> 0 next cycle, then 1 on the following conflict.
- With SR_FF_BANK_SYNC_EN: s[0] pulse at edge N -> q[0]=1 after edge N+2; rst asserted one cycle after the pulse -> q[0] stays 0 after release.
